mac_accumulator: RTL and testbench

Downstream stage of the 3x3 `array_multiplier`. Consumes its 6-bit products through a valid/ready handshake and sums a frame of products, where a frame is terminated by `in_last`. Presents one registered result per frame (sum and product count) on a valid/ready output. Together the two blocks form the team's small multiply-accumulate datapath.

---
 rtl/mac_accumulator_if.sv | 26 ++
 rtl/mac_accumulator.sv | 104 ++++++++++
 tb/tb_mac_accumulator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for mac_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface mac_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_len;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_ovf
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Frame accumulator behind array_multiplier: sums products until in_last.
// Define MAC_ACC_SAT_EN for a saturating sum with out_ovf reporting.
module mac_accumulator #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  mac_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] len;
  logic [ACC_W-1:0] sum_q;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic [LEN_W-1:0] len_next;

  assign accept   = bus.in_valid & bus.in_ready;
  assign sum_wide = {1'b0, acc} + {{(ACC_W-5){1'b0}}, bus.in_prod};
  assign len_next = len + 1'b1;

`ifdef MAC_ACC_SAT_EN
  logic ovf_now;
  logic sticky;
  logic ovf_q;

  assign ovf_now  = sum_wide[ACC_W];
  assign sum_next = ovf_now ? '1 : sum_wide[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        ovf_q  <= sticky | ovf_now;
        sticky <= 1'b0;
      end else begin
        sticky <= sticky | ovf_now;
      end
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  logic unused_carry;

  assign unused_carry = sum_wide[ACC_W];
  assign sum_next     = sum_wide[ACC_W-1:0];
  assign bus.out_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   if (accept && bus.in_last) state_nx = HOLD;
      HOLD:    if (bus.out_ready)         state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      ACCUM:   bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      len   <= '0;
      sum_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        sum_q <= sum_next;
        len_q <= len_next;
        acc   <= '0;
        len   <= '0;
      end else begin
        acc <= sum_next;
        len <= len_next;
      end
    end
  end

  assign bus.out_sum = sum_q;
  assign bus.out_len = len_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default width plus a 6-bit instance.
// Expected values for the 6-bit case follow MAC_ACC_SAT_EN.
module tb_mac_accumulator;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mac_accumulator_if #(.ACC_W(12), .LEN_W(8)) b12 ();
  mac_accumulator_if #(.ACC_W(6),  .LEN_W(8)) b6 ();

  mac_accumulator #(.ACC_W(12), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b12)
  );

  mac_accumulator #(.ACC_W(6), .LEN_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic send(input bit s, input logic [5:0] p, input bit l);
    bit done;
    done = 1'b0;
    if (s) begin
      b6.in_valid = 1'b1; b6.in_prod = p; b6.in_last = l;
    end else begin
      b12.in_valid = 1'b1; b12.in_prod = p; b12.in_last = l;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      if ((s ? b6.in_ready : b12.in_ready) === 1'b1) done = 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout prod=%0d got no in_ready want accept", p);
    end
    b6.in_valid  = 1'b0;
    b12.in_valid = 1'b0;
  endtask

  // Shift-add 3x3 multiply, standing in for array_multiplier.
  function automatic logic [5:0] mul3(input logic [2:0] a, input logic [2:0] b);
    logic [5:0] r;
    r = '0;
    for (int k = 0; k < 3; k++)
      if (b[k]) r = r + ({3'b000, a} << k);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (b12.in_ready !== 1'b1 || b12.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1/0",
               b12.in_ready, b12.out_valid);
    end
    checks++;
    if (b12.out_sum !== 12'd0 || b12.out_len !== 8'd0 || b12.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got sum=%0d len=%0d ovf=%b want 0/0/0",
               b12.out_sum, b12.out_len, b12.out_ovf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    b12.out_ready = 1'b1;
    send(0, 6'd20, 0);
    send(0, 6'd35, 0);
    send(0, 6'd5, 0);
    send(0, 6'd49, 1);
    checks++;
    if (b12.out_valid !== 1'b1 || b12.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_hold got vld=%b rdy=%b want 1/0",
               b12.out_valid, b12.in_ready);
    end
    checks++;
    if (b12.out_sum !== 12'd109 || b12.out_len !== 8'd4) begin
      errors++;
      $display("FAIL frame_sum got sum=%0d len=%0d want 109/4",
               b12.out_sum, b12.out_len);
    end
    tick();
    checks++;
    if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_release got vld=%b rdy=%b want 0/1",
               b12.out_valid, b12.in_ready);
    end
  endtask

  task automatic test_hold();
    b12.out_ready = 1'b0;
    send(0, 6'd20, 0);
    send(0, 6'd35, 0);
    send(0, 6'd5, 0);
    send(0, 6'd49, 1);
    b12.in_valid = 1'b1; b12.in_prod = 6'd9; b12.in_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (b12.out_valid !== 1'b1 || b12.in_ready !== 1'b0 ||
          b12.out_sum !== 12'd109 || b12.out_len !== 8'd4) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got vld=%b rdy=%b sum=%0d len=%0d want 1/0/109/4",
                 i, b12.out_valid, b12.in_ready, b12.out_sum, b12.out_len);
      end
      if (i < 5) tick();
    end
    b12.out_ready = 1'b1;
    tick();
    checks++;
    if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b want 0/1",
               b12.out_valid, b12.in_ready);
    end
    tick();
    b12.in_valid = 1'b0;
    checks++;
    if (b12.out_valid !== 1'b1 || b12.out_sum !== 12'd9 || b12.out_len !== 8'd1) begin
      errors++;
      $display("FAIL hold_not_lost got vld=%b sum=%0d len=%0d want 1/9/1",
               b12.out_valid, b12.out_sum, b12.out_len);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    b12.out_ready = 1'b1;
    send(0, 6'd9, 1);
    checks++;
    if (b12.out_valid !== 1'b1 || b12.out_sum !== 12'd9 || b12.out_len !== 8'd1) begin
      errors++;
      $display("FAIL b2b_first got vld=%b sum=%0d len=%0d want 1/9/1",
               b12.out_valid, b12.out_sum, b12.out_len);
    end
    send(0, 6'd36, 1);
    checks++;
    if (b12.out_valid !== 1'b1 || b12.out_sum !== 12'd36 || b12.out_len !== 8'd1) begin
      errors++;
      $display("FAIL b2b_second got vld=%b sum=%0d len=%0d want 1/36/1",
               b12.out_valid, b12.out_sum, b12.out_len);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [5:0] want_sum;
    logic       want_ovf;
`ifdef MAC_ACC_SAT_EN
    want_sum = 6'd63;
    want_ovf = 1'b1;
`else
    want_sum = 6'd34;
    want_ovf = 1'b0;
`endif
    b6.out_ready = 1'b1;
    send(1, 6'd49, 0);
    send(1, 6'd49, 1);
    checks++;
    if (b6.out_valid !== 1'b1 || b6.out_sum !== want_sum ||
        b6.out_len !== 8'd2 || b6.out_ovf !== want_ovf) begin
      errors++;
      $display("FAIL ovf_frame got vld=%b sum=%0d len=%0d ovf=%b want 1/%0d/2/%b",
               b6.out_valid, b6.out_sum, b6.out_len, b6.out_ovf, want_sum, want_ovf);
    end
    send(1, 6'd1, 1);
    checks++;
    if (b6.out_sum !== 6'd1 || b6.out_len !== 8'd1 || b6.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got sum=%0d len=%0d ovf=%b want 1/1/0",
               b6.out_sum, b6.out_len, b6.out_ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    b12.out_ready = 1'b1;
    send(0, 6'd10, 0);
    send(0, 6'd12, 0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (b12.in_ready !== 1'b1 || b12.out_valid !== 1'b0 || b12.out_sum !== 12'd0 ||
        b12.out_len !== 8'd0 || b12.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_out got rdy=%b vld=%b sum=%0d len=%0d ovf=%b want 1/0/0/0/0",
               b12.in_ready, b12.out_valid, b12.out_sum, b12.out_len, b12.out_ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 6'd7, 1);
    checks++;
    if (b12.out_valid !== 1'b1 || b12.out_sum !== 12'd7 || b12.out_len !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_frame got vld=%b sum=%0d len=%0d want 1/7/1",
               b12.out_valid, b12.out_sum, b12.out_len);
    end
    tick();
  endtask

  task automatic test_multiplier();
    logic [2:0]  ta [3];
    logic [2:0]  tb [3];
    logic [5:0]  p;
    logic [11:0] gold;
    ta[0] = 3'd4; tb[0] = 3'd5;
    ta[1] = 3'd7; tb[1] = 3'd5;
    ta[2] = 3'd1; tb[2] = 3'd5;
    gold = '0;
    b12.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = mul3(ta[i], tb[i]);
      checks++;
      if ({6'd0, p} !== 12'(ta[i] * tb[i])) begin
        errors++;
        $display("FAIL mult_prod i=%0d got %0d want %0d", i, p, ta[i] * tb[i]);
      end
      gold = gold + 12'(ta[i] * tb[i]);
      send(0, p, i == 2);
    end
    checks++;
    if (b12.out_valid !== 1'b1 || b12.out_sum !== gold || b12.out_len !== 8'd3) begin
      errors++;
      $display("FAIL mult_sum got vld=%b sum=%0d len=%0d want 1/%0d/3",
               b12.out_valid, b12.out_sum, b12.out_len, gold);
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    b12.in_valid = 1'b0; b12.in_prod = '0; b12.in_last = 1'b0; b12.out_ready = 1'b0;
    b6.in_valid  = 1'b0; b6.in_prod  = '0; b6.in_last  = 1'b0; b6.out_ready  = 1'b0;
    test_reset();
    test_frame();
    test_hold();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_multiplier();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
